mc_control: RTL and testbench
=============================

# mc_control

Multi-cycle control FSM for the lab CPU datapath. It sequences each instruction through fetch, decode, execute, memory and write-back cycles. Every cycle it drives the write enables and the select inputs of the datapath's 2:1 and 4:1 word muxes (PC source, ALU operands, register destination, write-back source). It sits directly upstream of those muxes and consumes only the opcode/funct fields and the ALU zero flag.

## Interface
- No parameters. Encodings below are fixed.
- `clk` in 1: sole clock; all state changes occur on the rising edge.
- `reset` in 1: asynchronous, active-high; forces state IDLE immediately.
- `opcode` in 6: IR[31:26], taken from the instruction register (already latched by the datapath).
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag, combinational from the datapath in the same cycle.
- `pc_we` out 1: PC register write enable.
- `ir_we` out 1: instruction register write enable.
- `tgt_we` out 1: branch-target register write enable.
- `reg_we` out 1: register file write enable.
- `mem_we` out 1: data memory write enable.
- `alu_src_a` out 1: 0 = PC, 1 = rs.
- `alu_src_b` out 2: 0 = rt, 1 = constant 4, 2 = extended imm, 3 = sign-ext imm<<2.
- `imm_zext` out 1: 1 = zero-extend imm (XORI only), 0 = sign-extend.
- `alu_op` out 2: 0 = ADD, 1 = SUB, 2 = XOR, 3 = SLT.
- `pc_src` out 2: 0 = ALU result, 1 = target register, 2 = {PC[31:28], IR[25:0], 2'b00}, 3 = rs.
- `reg_dst` out 2: 0 = rt, 1 = rd, 2 = 31.
- `mem_to_reg` out 2: 0 = ALU result, 1 = memory data, 2 = PC.
- `state` out 4: current state encoding, for debug.
- `illegal` out 1: sticky flag set on an unsupported instruction.

## Operation
- Moore machine. Outputs are decoded from the registered state only; `pc_we` in BNE also depends on `zero`. Any output not listed for a state is 0.
- Supported instructions:
  - LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, ADDI 0x08.
  - R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- State encodings and outputs:
  - IDLE 0: all outputs 0.
  - FETCH 1: `ir_we`=1, `pc_we`=1, `alu_src_a`=0, `alu_src_b`=1, `alu_op`=ADD, `pc_src`=0 (PC <= PC+4).
  - DECODE 2: `tgt_we`=1, `alu_src_a`=0, `alu_src_b`=3, `alu_op`=ADD.
  - EXEC_R 3: `alu_src_a`=1, `alu_src_b`=0, `alu_op` from funct.
  - EXEC_I 4: `alu_src_a`=1, `alu_src_b`=2; ADD for ADDI, XOR plus `imm_zext`=1 for XORI.
  - MEM_ADDR 5: `alu_src_a`=1, `alu_src_b`=2, `alu_op`=ADD.
  - MEM_RD 6: holds the address controls of MEM_ADDR.
  - MEM_WR 7: holds the address controls of MEM_ADDR; `mem_we`=1.
  - WB_ALU 8: `reg_we`=1, `mem_to_reg`=0; `reg_dst`=1 for R-type, 0 for I-type.
  - WB_MEM 9: `reg_we`=1, `mem_to_reg`=1, `reg_dst`=0.
  - BRANCH 10: `alu_src_a`=1, `alu_src_b`=0, `alu_op`=SUB, `pc_src`=1, `pc_we`=~`zero`.
  - JUMP 11: `pc_we`=1, `pc_src`=2; for JAL also `reg_we`=1, `reg_dst`=2, `mem_to_reg`=2.
  - JR 12: `pc_we`=1, `pc_src`=3.
- Transitions:
  - IDLE -> FETCH -> DECODE.
  - DECODE dispatches on opcode/funct: R-type ALU -> EXEC_R; ADDI/XORI -> EXEC_I; LW/SW -> MEM_ADDR; BNE -> BRANCH; J/JAL -> JUMP; JR -> JR.
  - EXEC_R, EXEC_I -> WB_ALU -> FETCH.
  - MEM_ADDR -> MEM_RD (LW) or MEM_WR (SW).
  - MEM_RD -> WB_MEM -> FETCH.
  - MEM_WR, BRANCH, JUMP, JR -> FETCH.
- Illegal opcode, or R-type with an unknown funct: DECODE -> FETCH with no writes; `illegal` is set and held until reset.
- The datapath latches the ALU result into its ALU-output register every cycle; the FSM assumes this.
- Unused state encodings 13-15 go to FETCH on the next edge and set `illegal`.

## Timing
- Reset asserted: state = IDLE and `illegal` = 0 immediately, asynchronously. All outputs are 0 while reset is high.
- First rising edge after reset deasserts: IDLE -> FETCH.
- Cycles per instruction, counted from FETCH:
  - R-type ALU, ADDI, XORI: 4.
  - LW: 5.
  - SW: 4.
  - BNE, J, JAL, JR: 3.
- PC is written exactly once per instruction in FETCH. Jumps and JR write it a second time; BNE writes it a second time only when taken.
- `mem_we` and `reg_we` are each asserted for exactly one cycle per instruction that uses them, and never in the same cycle.
- Reset asserted mid-instruction aborts the instruction. No partial write occurs after the reset edge, and the next instruction starts from FETCH.

## Test plan
- Reset high for 3 cycles, then release -> all outputs 0 during reset; `state` goes 0, then 1, then 2 on successive edges.
- ADD (opcode 0x00, funct 0x20) -> states 1, 2, 3, 8, 1; `reg_we`=1 only in state 8 with `reg_dst`=1; `alu_op`=0 in state 3.
- LW 0x23, then SW 0x2B -> LW runs 5 cycles with `mem_to_reg`=1 in WB_MEM; SW runs 4 cycles with `mem_we`=1 only in state 7 and `reg_we` never 1.
- BNE with `zero`=0, then `zero`=1 -> `pc_we`=1 and `pc_src`=1 in state 10 for the first; `pc_we`=0 in state 10 for the second.
- JAL 0x03 -> state 11 with `pc_we`=1, `pc_src`=2, `reg_we`=1, `reg_dst`=2, `mem_to_reg`=2. JR (0x00/0x08) -> state 12 with `pc_src`=3.
- Opcode 0x3F -> DECODE returns to FETCH with no writes and `illegal`=1. A later legal ADD still executes with `illegal` held at 1. Asserting reset clears `illegal`.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle control FSM: sequences each instruction through fetch, decode, execute, memory and write-back.
// Latency: 3-5 cycles per instruction counted from FETCH; outputs are decoded from the registered state.
// Backpressure: none; the FSM advances every cycle and the datapath must keep up.
//
// Ports:
//   i_clk, i_reset      : clock; asynchronous active-high reset to IDLE that also clears the illegal flag
//   i_opcode, i_funct   : IR[31:26] and IR[5:0] from the latched instruction register
//   i_zero              : ALU zero flag, used only in BRANCH (BNE)
//   o_pc_we/o_ir_we/o_tgt_we/o_reg_we/o_mem_we : write enables
//   o_alu_src_a/o_alu_src_b/o_imm_zext/o_alu_op/o_pc_src/o_reg_dst/o_mem_to_reg : datapath mux selects
//   o_state             : current state encoding (debug)
//   o_illegal           : sticky unsupported-instruction flag
module mc_control (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [5:0] i_opcode,
  input  logic [5:0] i_funct,
  input  logic       i_zero,
  output logic       o_pc_we,
  output logic       o_ir_we,
  output logic       o_tgt_we,
  output logic       o_reg_we,
  output logic       o_mem_we,
  output logic       o_alu_src_a,
  output logic [1:0] o_alu_src_b,
  output logic       o_imm_zext,
  output logic [1:0] o_alu_op,
  output logic [1:0] o_pc_src,
  output logic [1:0] o_reg_dst,
  output logic [1:0] o_mem_to_reg,
  output logic [3:0] o_state,
  output logic       o_illegal
);

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // ALU operations
  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;
  localparam logic [1:0] ALU_XOR = 2'd2;
  localparam logic [1:0] ALU_SLT = 2'd3;

  // Mux select encodings
  localparam logic [1:0] SRCB_RT    = 2'd0;
  localparam logic [1:0] SRCB_FOUR  = 2'd1;
  localparam logic [1:0] SRCB_IMM   = 2'd2;
  localparam logic [1:0] SRCB_BROFF = 2'd3;
  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_TGT    = 2'd1;
  localparam logic [1:0] PCS_JADDR  = 2'd2;
  localparam logic [1:0] PCS_RS     = 2'd3;
  localparam logic [1:0] DST_RT     = 2'd0;
  localparam logic [1:0] DST_RD     = 2'd1;
  localparam logic [1:0] DST_RA     = 2'd2;
  localparam logic [1:0] WB_ALUOUT  = 2'd0;
  localparam logic [1:0] WB_MDR     = 2'd1;
  localparam logic [1:0] WB_PC      = 2'd2;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_EXEC_I   = 4'd4,
    S_MEM_ADDR = 4'd5,
    S_MEM_RD   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_WB_ALU   = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JR       = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_illegal;
  logic   w_set_illegal;

  // The IR is stable from DECODE until the next FETCH, so later states can
  // keep looking at opcode/funct instead of storing a decoded copy.
  logic w_rtype;
  logic w_rtype_alu;
  logic w_rtype_jr;

  assign w_rtype     = (i_opcode == OP_RTYPE);
  assign w_rtype_alu = w_rtype && ((i_funct == FN_ADD) || (i_funct == FN_SUB) || (i_funct == FN_SLT));
  assign w_rtype_jr  = w_rtype && (i_funct == FN_JR);

  // State register
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_illegal <= r_illegal | w_set_illegal;
    end
  end

  // Next-state logic
  always_comb begin
    w_next        = S_FETCH;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        if (w_rtype_alu) begin
          w_next = S_EXEC_R;
        end else if (w_rtype_jr) begin
          w_next = S_JR;
        end else begin
          case (i_opcode)
            OP_ADDI, OP_XORI: w_next = S_EXEC_I;
            OP_LW, OP_SW:     w_next = S_MEM_ADDR;
            OP_BNE:           w_next = S_BRANCH;
            OP_J, OP_JAL:     w_next = S_JUMP;
            default: begin
              // Unknown opcode or unknown R-type funct: skip to the next fetch, no writes.
              w_next        = S_FETCH;
              w_set_illegal = 1'b1;
            end
          endcase
        end
      end
      S_EXEC_R:   w_next = S_WB_ALU;
      S_EXEC_I:   w_next = S_WB_ALU;
      S_MEM_ADDR: w_next = (i_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = S_WB_MEM;
      S_MEM_WR:   w_next = S_FETCH;
      S_WB_ALU:   w_next = S_FETCH;
      S_WB_MEM:   w_next = S_FETCH;
      S_BRANCH:   w_next = S_FETCH;
      S_JUMP:     w_next = S_FETCH;
      S_JR:       w_next = S_FETCH;
      default: begin
        // Encodings 13-15 are unreachable in normal operation; recover and flag it.
        w_next        = S_FETCH;
        w_set_illegal = 1'b1;
      end
    endcase
  end

  // Output decode
  always_comb begin
    o_pc_we      = 1'b0;
    o_ir_we      = 1'b0;
    o_tgt_we     = 1'b0;
    o_reg_we     = 1'b0;
    o_mem_we     = 1'b0;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = SRCB_RT;
    o_imm_zext   = 1'b0;
    o_alu_op     = ALU_ADD;
    o_pc_src     = PCS_ALU;
    o_reg_dst    = DST_RT;
    o_mem_to_reg = WB_ALUOUT;
    case (r_state)
      S_FETCH: begin
        o_ir_we     = 1'b1;
        o_pc_we     = 1'b1;
        o_alu_src_b = SRCB_FOUR;
      end
      S_DECODE: begin
        // Speculatively compute the branch target while the IR is decoded.
        o_tgt_we    = 1'b1;
        o_alu_src_b = SRCB_BROFF;
      end
      S_EXEC_R: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_RT;
        case (i_funct)
          FN_SUB:  o_alu_op = ALU_SUB;
          FN_SLT:  o_alu_op = ALU_SLT;
          default: o_alu_op = ALU_ADD;
        endcase
      end
      S_EXEC_I: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        if (i_opcode == OP_XORI) begin
          o_alu_op   = ALU_XOR;
          o_imm_zext = 1'b1;
        end
      end
      S_MEM_ADDR, S_MEM_RD: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
      end
      S_MEM_WR: begin
        o_alu_src_a = 1'b1;
        o_alu_src_b = SRCB_IMM;
        o_mem_we    = 1'b1;
      end
      S_WB_ALU: begin
        o_reg_we  = 1'b1;
        o_reg_dst = w_rtype ? DST_RD : DST_RT;
      end
      S_WB_MEM: begin
        o_reg_we     = 1'b1;
        o_mem_to_reg = WB_MDR;
      end
      S_BRANCH: begin
        // BNE: rs - rt; PC takes the target computed in DECODE only when not equal.
        o_alu_src_a = 1'b1;
        o_alu_op    = ALU_SUB;
        o_pc_src    = PCS_TGT;
        o_pc_we     = ~i_zero;
      end
      S_JUMP: begin
        o_pc_we  = 1'b1;
        o_pc_src = PCS_JADDR;
        if (i_opcode == OP_JAL) begin
          // PC already holds the return address (PC+4) from FETCH.
          o_reg_we     = 1'b1;
          o_reg_dst    = DST_RA;
          o_mem_to_reg = WB_PC;
        end
      end
      S_JR: begin
        o_pc_we  = 1'b1;
        o_pc_src = PCS_RS;
      end
      default: ;
    endcase
  end

  assign o_state   = r_state;
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       pc_we, ir_we, tgt_we, reg_we, mem_we, alu_src_a, imm_zext, illegal;
  logic [1:0] alu_src_b, alu_op, pc_src, reg_dst, mem_to_reg;
  logic [3:0] state;

  mc_control dut (
    .i_clk(clk), .i_reset(reset), .i_opcode(opcode), .i_funct(funct), .i_zero(zero),
    .o_pc_we(pc_we), .o_ir_we(ir_we), .o_tgt_we(tgt_we), .o_reg_we(reg_we), .o_mem_we(mem_we),
    .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_imm_zext(imm_zext), .o_alu_op(alu_op),
    .o_pc_src(pc_src), .o_reg_dst(reg_dst), .o_mem_to_reg(mem_to_reg), .o_state(state),
    .o_illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we, ir_we, tgt_we, reg_we, mem_we, a;
    logic [1:0] b;
    logic       zext;
    logic [1:0] aluop, pcsrc, regdst, m2r;
    logic       ill;
  } exp_t;

  // One cycle of expected behaviour plus the inputs to apply in that cycle.
  typedef struct packed {
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    exp_t       e;
  } rec_t;

  rec_t q[$];
  bit   m_ill;
  int   n_vec, n_err;
  int   c_reg, c_mem, c_pc;

  logic [5:0] lop [11] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h23, 6'h2B, 6'h02, 6'h03, 6'h05, 6'h0E, 6'h08};
  logic [5:0] lfn [11] = '{6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};

  function automatic rec_t blank(input logic [5:0] op, input logic [5:0] fn);
    rec_t r;
    r.op    = op;
    r.fn    = fn;
    r.z     = 1'($urandom_range(0, 1));
    r.e     = '0;
    r.e.ill = m_ill;
    return r;
  endfunction

  // Expand one instruction into its per-cycle expectations, from FETCH onwards.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zbr);
    rec_t r;
    r = blank(op, fn); r.e.st = 4'd1; r.e.pc_we = 1; r.e.ir_we = 1; r.e.b = 2'd1; q.push_back(r);
    r = blank(op, fn); r.e.st = 4'd2; r.e.tgt_we = 1; r.e.b = 2'd3; q.push_back(r);
    if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A)) begin
      r = blank(op, fn); r.e.st = 4'd3; r.e.a = 1;
      r.e.aluop = (fn == 6'h20) ? 2'd0 : (fn == 6'h22) ? 2'd1 : 2'd3; q.push_back(r);
      r = blank(op, fn); r.e.st = 4'd8; r.e.reg_we = 1; r.e.regdst = 2'd1; q.push_back(r);
    end else if (op == 6'h00 && fn == 6'h08) begin
      r = blank(op, fn); r.e.st = 4'd12; r.e.pc_we = 1; r.e.pcsrc = 2'd3; q.push_back(r);
    end else if (op == 6'h08 || op == 6'h0E) begin
      r = blank(op, fn); r.e.st = 4'd4; r.e.a = 1; r.e.b = 2'd2;
      if (op == 6'h0E) begin r.e.aluop = 2'd2; r.e.zext = 1; end
      q.push_back(r);
      r = blank(op, fn); r.e.st = 4'd8; r.e.reg_we = 1; q.push_back(r);
    end else if (op == 6'h23 || op == 6'h2B) begin
      r = blank(op, fn); r.e.st = 4'd5; r.e.a = 1; r.e.b = 2'd2; q.push_back(r);
      if (op == 6'h23) begin
        r = blank(op, fn); r.e.st = 4'd6; r.e.a = 1; r.e.b = 2'd2; q.push_back(r);
        r = blank(op, fn); r.e.st = 4'd9; r.e.reg_we = 1; r.e.m2r = 2'd1; q.push_back(r);
      end else begin
        r = blank(op, fn); r.e.st = 4'd7; r.e.a = 1; r.e.b = 2'd2; r.e.mem_we = 1; q.push_back(r);
      end
    end else if (op == 6'h05) begin
      r = blank(op, fn); r.z = zbr; r.e.st = 4'd10; r.e.a = 1; r.e.aluop = 2'd1;
      r.e.pcsrc = 2'd1; r.e.pc_we = ~zbr; q.push_back(r);
    end else if (op == 6'h02 || op == 6'h03) begin
      r = blank(op, fn); r.e.st = 4'd11; r.e.pc_we = 1; r.e.pcsrc = 2'd2;
      if (op == 6'h03) begin r.e.reg_we = 1; r.e.regdst = 2'd2; r.e.m2r = 2'd2; end
      q.push_back(r);
    end else begin
      m_ill = 1'b1;  // becomes visible from the next FETCH
    end
  endtask

  task automatic chk(input exp_t e, input string nm);
    exp_t a;
    a.st = state; a.pc_we = pc_we; a.ir_we = ir_we; a.tgt_we = tgt_we; a.reg_we = reg_we;
    a.mem_we = mem_we; a.a = alu_src_a; a.b = alu_src_b; a.zext = imm_zext; a.aluop = alu_op;
    a.pcsrc = pc_src; a.regdst = reg_dst; a.m2r = mem_to_reg; a.ill = illegal;
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s t=%0t op=%h fn=%h z=%b: got %h expected %h", nm, $time, opcode, funct, zero, a, e);
    end
  endtask

  task automatic chk_int(input string nm, input int got, input int expv);
    n_vec++;
    if (got != expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, expv);
    end
  endtask

  task automatic play(input int n, input string nm);
    for (int i = 0; i < n && q.size() > 0; i++) begin
      rec_t r;
      r = q.pop_front();
      @(posedge clk);
      #1;
      opcode = r.op; funct = r.fn; zero = r.z;
      @(negedge clk);
      chk(r.e, nm);
      c_reg += int'(reg_we); c_mem += int'(mem_we); c_pc += int'(pc_we);
    end
  endtask

  // Called just after a negedge: assert reset asynchronously, hold, release.
  task automatic do_reset(input int ncyc);
    #2 reset = 1'b1;
    #1 chk('0, "rst_async");
    q.delete();
    m_ill = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      zero = 1'($urandom_range(0, 1));
      chk('0, "rst_hold");
    end
    #1 reset = 1'b0;
    #1 chk('0, "rst_idle");
  endtask

  task automatic dir(input logic [5:0] op, input logic [5:0] fn, input logic z, input string nm,
                     input int len, input int rw, input int mw, input int pw);
    int n;
    build(op, fn, z);
    n = q.size();
    chk_int({nm, "_len"}, n, len);
    c_reg = 0; c_mem = 0; c_pc = 0;
    play(n, nm);
    chk_int({nm, "_reg_we_cnt"}, c_reg, rw);
    chk_int({nm, "_mem_we_cnt"}, c_mem, mw);
    chk_int({nm, "_pc_we_cnt"}, c_pc, pw);
  endtask

  function automatic bit legal_op(input logic [5:0] op);
    return op == 6'h00 || op == 6'h02 || op == 6'h03 || op == 6'h05 || op == 6'h08 ||
           op == 6'h0E || op == 6'h23 || op == 6'h2B;
  endfunction

  initial begin
    n_vec = 0; n_err = 0; m_ill = 1'b0;
    reset = 1'b0; opcode = 6'h00; funct = 6'h00; zero = 1'b0;
    @(negedge clk);
    do_reset(3);

    // Directed: name, len, reg_we count, mem_we count, pc_we count
    dir(6'h00, 6'h20, 1'b0, "add",      4, 1, 0, 1);
    dir(6'h23, 6'h00, 1'b0, "lw",       5, 1, 0, 1);
    dir(6'h2B, 6'h00, 1'b0, "sw",       4, 0, 1, 1);
    dir(6'h05, 6'h00, 1'b0, "bne_tk",   3, 0, 0, 2);
    dir(6'h05, 6'h00, 1'b1, "bne_nt",   3, 0, 0, 1);
    dir(6'h03, 6'h00, 1'b0, "jal",      3, 1, 0, 2);
    dir(6'h02, 6'h00, 1'b0, "j",        3, 0, 0, 2);
    dir(6'h00, 6'h08, 1'b0, "jr",       3, 0, 0, 2);
    dir(6'h0E, 6'h00, 1'b0, "xori",     4, 1, 0, 1);
    dir(6'h08, 6'h00, 1'b0, "addi",     4, 1, 0, 1);
    dir(6'h00, 6'h22, 1'b0, "sub",      4, 1, 0, 1);
    dir(6'h00, 6'h2A, 1'b0, "slt",      4, 1, 0, 1);
    dir(6'h3F, 6'h00, 1'b0, "ill_op",   2, 0, 0, 1);
    dir(6'h00, 6'h20, 1'b0, "add_ill",  4, 1, 0, 1);
    chk_int("illegal_held", int'(illegal), 1);
    dir(6'h00, 6'h01, 1'b0, "ill_fn",   2, 0, 0, 1);

    // Abort an LW in MEM_ADDR; reset must clear illegal and restart from FETCH.
    build(6'h23, 6'h00, 1'b0);
    play(3, "lw_abort");
    do_reset(2);
    chk_int("illegal_cleared", int'(illegal), 0);
    dir(6'h00, 6'h20, 1'b0, "add_post", 4, 1, 0, 1);

    // Randomized instruction stream
    for (int k = 0; k < 300; k++) begin
      int sel;
      logic [5:0] op, fn;
      sel = $urandom_range(0, 13);
      if (sel < 11) begin
        op = lop[sel]; fn = lfn[sel];
      end else if (sel == 11) begin
        op = 6'($urandom_range(0, 63));
        while (legal_op(op)) op = 6'($urandom_range(0, 63));
        fn = 6'($urandom_range(0, 63));
      end else begin
        op = 6'h00;
        fn = 6'($urandom_range(0, 63));
        while (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A || fn == 6'h08) fn = 6'($urandom_range(0, 63));
      end
      build(op, fn, 1'($urandom_range(0, 1)));
      if (k % 40 == 39 && q.size() > 2) begin
        play($urandom_range(1, q.size() - 1), "rand_abort");
        do_reset($urandom_range(1, 3));
      end else begin
        play(q.size(), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
